// File: rtl/enemy_row_controller_pkg.sv
// Shared enemy-row definitions: march phase encoding and width helpers.
package enemy_row_controller_pkg;

    typedef enum logic [1:0] {
        PH_MOVE_R = 2'b00,
        PH_DESC_R = 2'b01,
        PH_MOVE_L = 2'b10,
        PH_DESC_L = 2'b11
    } phase_e;

    // Index width for a row of n enemies (never zero bits).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enemy_row_controller_if.sv
// Frame/kill inputs and row state outputs of one enemy row.
interface enemy_row_controller_if
    import enemy_row_controller_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES = 8,
    parameter int unsigned POS_W       = 10
);
    localparam int unsigned IDX_W = idx_width(NUM_ENEMIES);

    logic                         i_FrameTick;
    logic                         i_Enable;
    logic                         i_KillValid;
    logic [IDX_W-1:0]             i_KillIndex;
    logic [NUM_ENEMIES*POS_W-1:0] o_EnemyHorizontalPosition;
    logic [POS_W-1:0]             o_RowVerticalPosition;
    logic [NUM_ENEMIES-1:0]       o_AliveMask;
    logic [1:0]                   o_PhaseState;
    logic                         o_StepPulse;
    logic                         o_AllDead;
    logic                         o_ReachedBottom;

    modport master (
        output i_FrameTick, i_Enable, i_KillValid, i_KillIndex,
        input  o_EnemyHorizontalPosition, o_RowVerticalPosition, o_AliveMask,
               o_PhaseState, o_StepPulse, o_AllDead, o_ReachedBottom
    );

    modport slave (
        input  i_FrameTick, i_Enable, i_KillValid, i_KillIndex,
        output o_EnemyHorizontalPosition, o_RowVerticalPosition, o_AliveMask,
               o_PhaseState, o_StepPulse, o_AllDead, o_ReachedBottom
    );
endinterface

// File: rtl/enemy_row_extent.sv
// Alive-mask extent: lowest/highest alive slot and number of alive slots.
module enemy_row_extent
    import enemy_row_controller_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES = 8,
    parameter int unsigned IDX_W       = idx_width(NUM_ENEMIES),
    parameter int unsigned ACNT_W      = $clog2(NUM_ENEMIES + 1)
) (
    input  logic [NUM_ENEMIES-1:0] i_Mask,
    output logic [IDX_W-1:0]       o_Lmin_c,
    output logic [IDX_W-1:0]       o_Rmax_c,
    output logic [ACNT_W-1:0]      o_AliveCount_c
);

    // Scan down for the lowest alive slot, up for the highest, counting as we go.
    always_comb begin
        o_Lmin_c       = '0;
        o_Rmax_c       = '0;
        o_AliveCount_c = '0;
        for (int i = int'(NUM_ENEMIES) - 1; i >= 0; i--) begin
            if (i_Mask[i]) o_Lmin_c = IDX_W'(i);
        end
        for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            if (i_Mask[i]) begin
                o_Rmax_c       = IDX_W'(i);
                o_AliveCount_c = o_AliveCount_c + ACNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/enemy_row_controller.sv
// One marching row of enemies: origin, alive mask, step pacing and 4-phase march.
module enemy_row_controller
    import enemy_row_controller_pkg::*;
#(
    parameter int unsigned     NUM_ENEMIES      = 8,
    parameter int unsigned     POS_W            = 10,
    parameter logic [POS_W-1:0] NONE            = '1,
    parameter int              SPACING          = 40,
    parameter int              STEP             = 2,
    parameter int              DROP             = 16,
    parameter int              LEFT_BOUND       = 16,
    parameter int              RIGHT_BOUND      = 600,
    parameter int              TOP_Y            = 32,
    parameter int              BOTTOM_BOUND     = 400,
    parameter int unsigned     FRAMES_PER_ENEMY = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    enemy_row_controller_if.slave  bus
);

    localparam int unsigned IDX_W  = idx_width(NUM_ENEMIES);
    localparam int unsigned ACNT_W = $clog2(NUM_ENEMIES + 1);
    localparam int unsigned CNT_W  = $clog2(NUM_ENEMIES * FRAMES_PER_ENEMY + 1);
    localparam int unsigned X_W    = POS_W + 1;

    // Reject parameter sets where a live slot could alias NONE or not fit the field.
    if (RIGHT_BOUND + STEP >= int'(NONE)) begin : g_bad_none
        $error("enemy_row_controller: RIGHT_BOUND + STEP must be below NONE");
    end
    if ((int'(NUM_ENEMIES) - 1) * SPACING + LEFT_BOUND > RIGHT_BOUND) begin : g_bad_width
        $error("enemy_row_controller: row does not fit between bounds");
    end

    phase_e                    r_phase, w_phase_n;
    logic signed [X_W-1:0]     r_row_x, w_row_x_n;
    logic [POS_W-1:0]          r_row_y, w_row_y_n;
    logic [NUM_ENEMIES-1:0]    r_mask, w_mask_n;
    logic [CNT_W-1:0]          r_count, w_count_n;
    logic                      r_step_pulse;
    logic                      r_all_dead;
    logic                      r_bottom, w_bottom_n;
    logic                      w_run;
    logic                      w_fire;
    logic [IDX_W-1:0]          w_lmin;
    logic [IDX_W-1:0]          w_rmax;
    logic [ACNT_W-1:0]         w_alive;
    logic [CNT_W-1:0]          w_period;
    logic [NUM_ENEMIES*POS_W-1:0] w_slot_x;

    enemy_row_extent #(
        .NUM_ENEMIES (NUM_ENEMIES),
        .IDX_W       (IDX_W),
        .ACNT_W      (ACNT_W)
    ) u_extent (
        .i_Mask         (r_mask),
        .o_Lmin_c       (w_lmin),
        .o_Rmax_c       (w_rmax),
        .o_AliveCount_c (w_alive)
    );

    // Step period shrinks with the alive count; an empty row still has period 1.
    assign w_period = (w_alive == '0) ? CNT_W'(1)
                                      : CNT_W'(w_alive) * CNT_W'(FRAMES_PER_ENEMY);

    // Next-state: frame pacing, march phase transitions, kills and landing flag.
    always_comb begin
        w_phase_n  = r_phase;
        w_row_x_n  = r_row_x;
        w_row_y_n  = r_row_y;
        w_mask_n   = r_mask;
        w_count_n  = r_count;
        w_bottom_n = r_bottom;
        w_run      = bus.i_FrameTick && bus.i_Enable && !r_all_dead && !r_bottom;
        // >= rather than == so a kill that shrinks the period fires on the next tick
        w_fire     = w_run && ((r_count + CNT_W'(1)) >= w_period);

        if (w_run) w_count_n = w_fire ? '0 : r_count + CNT_W'(1);

        // Bound checks use the pre-kill extent from r_mask.
        if (w_fire) begin
            case (r_phase)
                PH_MOVE_R: begin
                    if (int'(r_row_x) + int'(w_rmax) * SPACING + STEP > RIGHT_BOUND)
                        w_phase_n = PH_DESC_R;
                    else
                        w_row_x_n = r_row_x + X_W'(STEP);
                end
                PH_DESC_R: begin
                    w_row_y_n = r_row_y + POS_W'(DROP);
                    w_phase_n = PH_MOVE_L;
                    if (int'(w_row_y_n) >= BOTTOM_BOUND) w_bottom_n = 1'b1;
                end
                PH_MOVE_L: begin
                    if (int'(r_row_x) + int'(w_lmin) * SPACING < LEFT_BOUND + STEP)
                        w_phase_n = PH_DESC_L;
                    else
                        w_row_x_n = r_row_x - X_W'(STEP);
                end
                PH_DESC_L: begin
                    w_row_y_n = r_row_y + POS_W'(DROP);
                    w_phase_n = PH_MOVE_R;
                    if (int'(w_row_y_n) >= BOTTOM_BOUND) w_bottom_n = 1'b1;
                end
            endcase
        end

        // Out-of-range indices match no slot and are dropped.
        for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            if (bus.i_KillValid && (int'(bus.i_KillIndex) == i)) w_mask_n[i] = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_phase      <= PH_MOVE_R;
            r_row_x      <= X_W'(LEFT_BOUND);
            r_row_y      <= POS_W'(TOP_Y);
            r_mask       <= '1;
            r_count      <= '0;
            r_step_pulse <= 1'b0;
            r_all_dead   <= 1'b0;
            r_bottom     <= 1'b0;
        end else begin
            r_phase      <= w_phase_n;
            r_row_x      <= w_row_x_n;
            r_row_y      <= w_row_y_n;
            r_mask       <= w_mask_n;
            r_count      <= w_count_n;
            r_step_pulse <= w_fire;
            r_all_dead   <= (w_mask_n == '0);
            r_bottom     <= w_bottom_n;
        end
    end

    // Per-slot x from the registered origin; dead slots report NONE.
    always_comb begin
        w_slot_x = '0;
        for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            w_slot_x[i*POS_W +: POS_W] = r_mask[i] ? POS_W'(r_row_x + X_W'(i * SPACING)) : NONE;
        end
    end

    assign bus.o_EnemyHorizontalPosition = w_slot_x;
    assign bus.o_RowVerticalPosition     = r_row_y;
    assign bus.o_AliveMask               = r_mask;
    assign bus.o_PhaseState              = r_phase;
    assign bus.o_StepPulse               = r_step_pulse;
    assign bus.o_AllDead                 = r_all_dead;
    assign bus.o_ReachedBottom           = r_bottom;

endmodule

// File: tb/tb_enemy_row_controller.sv
// Bench for enemy_row_controller: behavioural row model plus directed scenarios.
module tb_enemy_row_controller;
    import enemy_row_controller_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned PW  = 10;
    localparam int SP = 40, ST = 2, DR = 16, LB = 16, RB = 600, TY = 32, BB = 400, FPE = 2;
    localparam logic [PW-1:0] NONE_V = 10'h3FF;

    logic clk = 1'b0;
    logic rst_n;

    enemy_row_controller_if #(.NUM_ENEMIES(N), .POS_W(PW)) bus ();

    enemy_row_controller #(
        .NUM_ENEMIES(N), .POS_W(PW), .NONE(NONE_V), .SPACING(SP), .STEP(ST), .DROP(DR),
        .LEFT_BOUND(LB), .RIGHT_BOUND(RB), .TOP_Y(TY), .BOTTOM_BOUND(BB), .FRAMES_PER_ENEMY(FPE)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (integer positions, list-style extent) -------------
    int       m_x, m_y, m_phase, m_cnt;
    bit       m_pulse, m_dead, m_bottom, m_valid = 1'b0;
    bit [N-1:0] m_mask;

    always @(posedge clk) begin
        int alive, lo, hi, per;
        bit fire;
        bit [N-1:0] nm;
        if (!rst_n) begin
            m_x = LB; m_y = TY; m_mask = '1; m_phase = 0; m_cnt = 0;
            m_pulse = 0; m_dead = 0; m_bottom = 0; m_valid = 1;
        end else begin
            alive = 0; lo = -1; hi = -1;
            for (int i = 0; i < int'(N); i++) begin
                if (m_mask[i]) begin
                    alive++;
                    if (lo < 0) lo = i;
                    hi = i;
                end
            end
            per = (alive * FPE < 1) ? 1 : alive * FPE;
            fire = 0;
            if (bus.i_FrameTick && bus.i_Enable && !m_dead && !m_bottom) begin
                if (m_cnt + 1 >= per) begin fire = 1; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end
            if (fire) begin
                case (m_phase)
                    0: if (m_x + hi * SP + ST > RB) m_phase = 1; else m_x = m_x + ST;
                    1: begin m_y = m_y + DR; m_phase = 2; if (m_y >= BB) m_bottom = 1; end
                    2: if (m_x + lo * SP < LB + ST) m_phase = 3; else m_x = m_x - ST;
                    default: begin m_y = m_y + DR; m_phase = 0; if (m_y >= BB) m_bottom = 1; end
                endcase
            end
            nm = m_mask;
            if (bus.i_KillValid && int'(bus.i_KillIndex) < int'(N)) nm[bus.i_KillIndex] = 1'b0;
            m_mask  = nm;
            m_dead  = (nm == '0);
            m_pulse = fire;
        end
    end

    // Every cycle after the first reset edge, DUT must agree with the model.
    always @(negedge clk) begin
        logic [N*PW-1:0] exp_pos;
        if (m_valid) begin
            exp_pos = '0;
            for (int i = 0; i < int'(N); i++)
                exp_pos[i*PW +: PW] = m_mask[i] ? PW'(m_x + i * SP) : NONE_V;
            check("model_pos",    80'(bus.o_EnemyHorizontalPosition), 80'(exp_pos));
            check("model_y",      80'(bus.o_RowVerticalPosition),     80'(m_y));
            check("model_mask",   80'(bus.o_AliveMask),               80'(m_mask));
            check("model_phase",  80'(bus.o_PhaseState),              80'(m_phase));
            check("model_pulse",  80'(bus.o_StepPulse),               80'(m_pulse));
            check("model_dead",   80'(bus.o_AllDead),                 80'(m_dead));
            check("model_bottom", 80'(bus.o_ReachedBottom),           80'(m_bottom));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_FrameTick = 1'b0; bus.i_Enable = 1'b0; bus.i_KillValid = 1'b0; bus.i_KillIndex = '0;
        cyc(3);
        rst_n = 1'b1;
    endtask

    task automatic kill(input int idx);
        bus.i_KillValid = 1'b1;
        bus.i_KillIndex = 3'(idx);
        cyc(1);
        bus.i_KillValid = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.o_StepPulse && cycles < budget);
        if (!bus.o_StepPulse) check({name, "_timeout"}, 80'(0), 80'(1));
    endtask

    task automatic wait_phase(input int ph, input int budget, input string name);
        int c;
        c = 0;
        while (int'(bus.o_PhaseState) != ph && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (int'(bus.o_PhaseState) != ph) check({name, "_timeout"}, 80'(bus.o_PhaseState), 80'(ph));
    endtask

    function automatic int slot(input int i);
        logic [N*PW-1:0] v;
        v = bus.o_EnemyHorizontalPosition;
        return int'(v[i*PW +: PW]);
    endfunction

    // Hard stop if a scenario hangs.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int c, pulses, last_y, n;
        int reset_x [N] = '{16, 56, 96, 136, 176, 216, 256, 296};

        do_reset();

        // Reset state.
        for (int i = 0; i < int'(N); i++) check("reset_slot_x", 80'(slot(i)), 80'(reset_x[i]));
        check("reset_y",      80'(bus.o_RowVerticalPosition), 80'(32));
        check("reset_mask",   80'(bus.o_AliveMask),           80'(8'hFF));
        check("reset_phase",  80'(bus.o_PhaseState),          80'(0));
        check("reset_pulse",  80'(bus.o_StepPulse),           80'(0));
        check("reset_dead",   80'(bus.o_AllDead),             80'(0));
        check("reset_bottom", 80'(bus.o_ReachedBottom),       80'(0));

        // First step after the 16th tick (P = 16 with a full row).
        bus.i_Enable = 1'b1; bus.i_FrameTick = 1'b1;
        cyc(15);
        check("no_early_step", 80'(bus.o_StepPulse), 80'(0));
        cyc(1);
        check("first_step_pulse", 80'(bus.o_StepPulse), 80'(1));
        check("first_step_x",     80'(slot(0)),         80'(18));

        // Full row reverses at RowX = 320.
        wait_phase(1, 5000, "right_edge");
        check("right_edge_x",     80'(slot(0)),                   80'(320));
        check("right_edge_y",     80'(bus.o_RowVerticalPosition), 80'(32));
        wait_pulse(100, "desc_r", c);
        check("desc_r_y",         80'(bus.o_RowVerticalPosition), 80'(48));
        check("desc_r_phase",     80'(bus.o_PhaseState),          80'(2));
        wait_pulse(100, "move_l", c);
        check("move_l_x",         80'(slot(0)),                   80'(318));

        // Kill slot 7: NONE next cycle, period drops to 14.
        bus.i_FrameTick = 1'b0;
        kill(7);
        check("kill7_slot", 80'(slot(7)),         80'(NONE_V));
        check("kill7_mask", 80'(bus.o_AliveMask), 80'(8'h7F));
        bus.i_FrameTick = 1'b1;
        wait_pulse(100, "p14_a", c);
        wait_pulse(100, "p14_b", c);
        check("period_after_kill", 80'(c), 80'(14));

        // Enable low freezes the march.
        bus.i_Enable = 1'b0;
        cyc(40);
        bus.i_Enable = 1'b1;

        // With slot 7 gone the right reversal happens at RowX = 360.
        wait_phase(3, 5000, "left_edge");
        check("left_edge_x", 80'(slot(0)), 80'(16));
        wait_phase(1, 8000, "right_edge_7");
        check("right_edge_7_x", 80'(slot(0)),                   80'(360));
        check("right_edge_7_y", 80'(bus.o_RowVerticalPosition), 80'(64));

        // Kill on the firing tick at RowX = 320: pre-kill mask still reverses.
        do_reset();
        bus.i_Enable = 1'b1; bus.i_FrameTick = 1'b1;
        c = 0;
        while (slot(0) != 320 && c < 3000) begin @(negedge clk); c++; end
        check("reach_320", 80'(slot(0)), 80'(320));
        cyc(15);
        kill(7);
        check("conc_pulse", 80'(bus.o_StepPulse),  80'(1));
        check("conc_phase", 80'(bus.o_PhaseState), 80'(1));
        check("conc_x",     80'(slot(0)),          80'(320));
        check("conc_mask",  80'(bus.o_AliveMask),  80'(8'h7F));

        // Kill everything; a repeated kill of slot 7 changes nothing.
        bus.i_FrameTick = 1'b0;
        kill(7);
        check("dead_kill_mask", 80'(bus.o_AliveMask), 80'(8'h7F));
        for (int i = 0; i < 6; i++) kill(i);
        check("not_all_dead", 80'(bus.o_AllDead), 80'(0));
        kill(6);
        check("all_dead",      80'(bus.o_AllDead),   80'(1));
        check("all_dead_mask", 80'(bus.o_AliveMask), 80'(0));
        bus.i_FrameTick = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_StepPulse) pulses++;
        end
        check("dead_no_steps", 80'(pulses), 80'(0));

        // Single survivor marches down to the bottom.
        do_reset();
        for (int i = 1; i < int'(N); i++) kill(i);
        bus.i_Enable = 1'b1; bus.i_FrameTick = 1'b1;
        last_y = 0; n = 0;
        while (!bus.o_ReachedBottom && n < 30000) begin
            last_y = int'(bus.o_RowVerticalPosition);
            @(negedge clk);
            n++;
        end
        check("bottom_set",    80'(bus.o_ReachedBottom),       80'(1));
        check("bottom_y",      80'(bus.o_RowVerticalPosition), 80'(400));
        check("bottom_pulse",  80'(bus.o_StepPulse),           80'(1));
        check("bottom_prev_y", 80'(last_y),                    80'(384));
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.o_StepPulse) pulses++;
        end
        check("bottom_no_steps", 80'(pulses), 80'(0));
        do_reset();
        check("bottom_cleared", 80'(bus.o_ReachedBottom),       80'(0));
        check("bottom_reset_y", 80'(bus.o_RowVerticalPosition), 80'(32));
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
